uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-producing requesters. It grants one requester at a time and captures that requester's byte. It issues a single-cycle data-valid to the transmitter, then holds off further grants until the transmitter reports completion and has returned to idle. A watchdog aborts a grant if completion never arrives. It sits between the core's byte sources (console, debug dump, status reporter) and the UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter that shares one UART transmitter between
//                NUM_REQ byte producers. It grants one requester at a time and
//                captures its byte. It issues a single-cycle data-valid, then
//                waits for transmitter done and a return to idle before the
//                next grant. A watchdog abandons a grant whose done never
//                arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 2604
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [2:0]           o_Grant_Id,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    // Watchdog compare value: the counter reads TIMEOUT_CLKS-1 on the
    // TIMEOUT_CLKS-th cycle spent waiting for done.
    localparam logic [23:0] c_WDOG_LAST = 24'(TIMEOUT_CLKS - 1);

    // Illegal configurations are rejected while the design elaborates.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
        end
        if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 16777215) begin : g_bad_timeout
            $error("uart_tx_arbiter: TIMEOUT_CLKS must be in 1..2^24-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_ptr;
    logic [23:0] r_wdog;

    logic               w_win_found;
    logic [2:0]         w_win;
    logic [2:0]         w_ptr_next;
    logic [7:0]         w_win_byte;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [3:0]         w_slot;

    // Rotating-priority search: first valid requester at or after r_ptr, with wrap.
    always_comb begin
        w_win_found  = 1'b0;
        w_win        = '0;
        w_slot       = '0;
        w_win_byte   = '0;
        w_win_onehot = '0;
        w_ptr_next   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slot = {1'b0, r_ptr} + 4'(i);
            if (w_slot >= 4'(NUM_REQ)) begin
                w_slot = w_slot - 4'(NUM_REQ);
            end
            for (int n = 0; n < NUM_REQ; n++) begin
                if (!w_win_found && w_slot == 4'(n) && i_Req_Valid[n]) begin
                    w_win_found = 1'b1;
                    w_win       = 3'(n);
                end
            end
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_win == 3'(n)) begin
                w_win_byte      = i_Req_Byte[8*n +: 8];
                w_win_onehot[n] = 1'b1;
            end
        end
        if ({1'b0, w_win} == 4'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_win + 3'd1;
        end
    end

    // Grant / wait-for-done / gap sequencer with registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_wdog     <= '0;
            o_Req_Ack  <= '0;
            o_Grant_Id <= '0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= '0;
            o_Busy     <= 1'b0;
            o_Timeout  <= 1'b0;
        end else begin
            o_Req_Ack <= '0;
            o_TX_DV   <= 1'b0;
            o_Timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A transmitter still finishing a frame (e.g. across our
                    // reset) blocks any new grant.
                    if (!i_TX_Active && !i_TX_Done && w_win_found) begin
                        o_Req_Ack  <= w_win_onehot;
                        o_TX_DV    <= 1'b1;
                        o_TX_Byte  <= w_win_byte;
                        o_Grant_Id <= w_win;
                        r_ptr      <= w_ptr_next;
                        r_wdog     <= '0;
                        r_state    <= WAIT_DONE;
                        o_Busy     <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    r_wdog <= r_wdog + 24'd1;
                    // Done wins over a coincident watchdog expiry.
                    if (i_TX_Done) begin
                        r_state <= GAP;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        o_Timeout <= 1'b1;
                        r_state   <= IDLE;
                        o_Busy    <= 1'b0;
                    end
                end
                GAP: begin
                    if (!i_TX_Done) begin
                        r_state <= IDLE;
                        o_Busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
